// File: rtl/uart_tx_frame_if.sv
// Byte-stream handshake between a producer and the UART transmitter's holding register.
// A word transfers on a rising edge where din_valid && din_ready; din is only meaningful while din_valid is high.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits, internal baud
// divider, and a one-entry holding register so consecutive frames run with no idle gap.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  uart_tx_frame_if.slave        in_if,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  frame_done,
  output logic [2:0]            state_dbg
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter value");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q, tx_d;
  logic                 cell_end;
  logic                 load;

  assign cell_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;

    if (in_if.din_valid && !hold_full_q) begin
      hold_d      = in_if.din;
      hold_full_d = 1'b1;
    end

    if (state_q != S_IDLE) cnt_d = cell_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE:  load = hold_full_q;
      S_START: if (cell_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (cell_end) begin
        if (bit_q == DATA_LAST) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          bit_d = bit_q + IW'(1);
        end
      end
      S_PARITY: if (cell_end) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (cell_end) begin
        if (bit_q == STOP_LAST) begin
          bit_d = '0;
          if (hold_full_q) load = 1'b1;
          else state_d = S_IDLE;
        end else begin
          bit_d = bit_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading empties the holding register in the same cycle; din_ready is low then, so no capture collides.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = S_START;
      cnt_d       = '0;
      bit_d       = '0;
    end

    // tx is registered from the next-state view so the line lines up with state_q every cycle.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_d];
      S_PARITY: tx_d = (PARITY == 1) ? ~(^shift_d) : ^shift_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

  assign in_if.din_ready = !hold_full_q;
  assign tx              = tx_q;
  assign tx_busy         = (state_q != S_IDLE) || hold_full_q;
  assign frame_done      = (state_q == S_STOP) && (bit_q == STOP_LAST) && cell_end;
  assign state_dbg       = state_q;

endmodule
